// File: rtl/jam_cost_server.sv
// Cost-table responder for the JAM core: loads 64 cost entries over a valid/ready stream,
// serves Cost = table[{W,J}] combinationally, and sequences the core's reset and completion.
module jam_cost_server #(
    parameter int N_IDX  = 8,
    parameter int IDX_W  = 3,
    parameter int COST_W = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [COST_W-1:0] load_data,
    output logic              load_ready,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost,
    output logic              jam_rst,
    input  logic              jam_valid,
    output logic              table_loaded,
    output logic              done
);

    localparam int N_ENT  = N_IDX * N_IDX;
    localparam int ADDR_W = 2 * IDX_W;

    typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              load_ready_nxt, jam_rst_nxt, table_loaded_nxt, done_nxt;
    logic              wr_en;
    logic [COST_W-1:0] cost_tbl [N_ENT];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= LOAD;
            idx          <= '0;
            load_ready   <= 1'b1;
            jam_rst      <= 1'b1;
            table_loaded <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            load_ready   <= load_ready_nxt;
            jam_rst      <= jam_rst_nxt;
            table_loaded <= table_loaded_nxt;
            done         <= done_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        idx_nxt          = idx;
        load_ready_nxt   = load_ready;
        jam_rst_nxt      = jam_rst;
        table_loaded_nxt = table_loaded;
        done_nxt         = done;
        wr_en            = 1'b0;
        case (state)
            LOAD: begin
                if (load_valid && load_ready) begin
                    wr_en = 1'b1;
                    if (idx == ADDR_W'(N_ENT - 1)) begin
                        state_nxt        = RUN;
                        idx_nxt          = '0;
                        table_loaded_nxt = 1'b1;
                        load_ready_nxt   = 1'b0;
                        jam_rst_nxt      = 1'b0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            RUN: begin
                if (jam_valid) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                if (load_start) begin
                    state_nxt        = LOAD;
                    idx_nxt          = '0;
                    jam_rst_nxt      = 1'b1;
                    done_nxt         = 1'b0;
                    table_loaded_nxt = 1'b0;
                    load_ready_nxt   = 1'b1;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N_ENT; i++) cost_tbl[i] <= '0;
        end else if (wr_en) begin
            cost_tbl[idx] <= load_data;
        end
    end

    // Zero-latency lookup: the core accumulates Cost in the same cycle it presents W/J.
    always_comb begin
        Cost = '0;
        if (state != LOAD) Cost = cost_tbl[{W, J}];
    end

endmodule

// File: tb/tb_jam_cost_server.sv
// Directed bench for jam_cost_server: load sequencing, lookups, reset and reload behaviour.
module tb_jam_cost_server;

    logic       CLK = 1'b0;
    logic       RST, load_start, load_valid, jam_valid;
    logic [6:0] load_data;
    logic [2:0] W, J;
    logic       load_ready, jam_rst, table_loaded, done;
    logic [6:0] Cost;

    int n_cmp = 0;
    int n_err = 0;
    int bad;

    jam_cost_server dut (
        .CLK(CLK), .RST(RST), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .W(W), .J(J), .Cost(Cost),
        .jam_rst(jam_rst), .jam_valid(jam_valid), .table_loaded(table_loaded), .done(done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic lookup(input string tag, input int w, input int j, input int exp);
        W = 3'(w);
        J = 3'(j);
        #1;
        chk(tag, 32'(Cost), 32'(exp));
    endtask

    // mode 0: entry k = k; mode 1: entry k = 63-k; mode 2: entry k = 127-k.
    // gappy drives load_valid in a repeating 1,0,0,1 pattern.
    task automatic load_entries(input string tag, input int mode, input int start,
                                input int count, input bit gappy);
        int k;
        int c;
        int nrdy;
        k = start;
        c = 0;
        nrdy = 0;
        while (k < start + count) begin
            if (!gappy || (c % 4 == 0) || (c % 4 == 3)) begin
                load_valid = 1'b1;
                load_data  = (mode == 0) ? 7'(k) : (mode == 1) ? 7'(63 - k) : 7'(127 - k);
                if (load_ready !== 1'b1) nrdy++;
                k++;
            end else begin
                load_valid = 1'b0;
                load_data  = 7'd100;
            end
            c++;
            tick();
        end
        load_valid = 1'b0;
        chk(tag, 32'(nrdy), 32'd0);
    endtask

    initial begin
        RST = 1'b1; load_start = 1'b0; load_valid = 1'b0; jam_valid = 1'b0;
        load_data = '0; W = 3'd2; J = 3'd5;
        tick();
        tick();
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_jam_rst", 32'(jam_rst), 32'd1);
        chk("rst_table_loaded", 32'(table_loaded), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        lookup("rst_cost", 2, 5, 0);
        RST = 1'b0;

        // Back-to-back load of k; completion lands on the edge after the 64th handshake.
        load_entries("s1_ready_a", 0, 0, 63, 1'b0);
        chk("s1_tl_before_last", 32'(table_loaded), 32'd0);
        chk("s1_jam_rst_before_last", 32'(jam_rst), 32'd1);
        load_entries("s1_ready_b", 0, 63, 1, 1'b0);
        chk("s1_table_loaded", 32'(table_loaded), 32'd1);
        chk("s1_jam_rst", 32'(jam_rst), 32'd0);
        chk("s1_load_ready_run", 32'(load_ready), 32'd0);
        lookup("s1_cost_2_5", 2, 5, 21);
        lookup("s1_cost_7_7", 7, 7, 63);

        // RUN: loads and load_start are ignored.
        bad = 0;
        load_valid = 1'b1; load_data = 7'd127; load_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (load_ready !== 1'b0) bad++;
            tick();
        end
        load_valid = 1'b0; load_start = 1'b0;
        chk("s3_load_ready_low", 32'(bad), 32'd0);
        chk("s3_jam_rst_still_low", 32'(jam_rst), 32'd0);
        chk("s3_done_not_yet", 32'(done), 32'd0);
        lookup("s3_cost_0_0", 0, 0, 0);
        lookup("s3_cost_2_5", 2, 5, 21);
        jam_valid = 1'b1;
        tick();
        jam_valid = 1'b0;
        chk("s3_done_set", 32'(done), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done !== 1'b1) bad++;
        end
        chk("s3_done_sticky", 32'(bad), 32'd0);
        chk("s3_done_jam_rst", 32'(jam_rst), 32'd0);
        chk("s3_done_table_loaded", 32'(table_loaded), 32'd1);
        lookup("s3_done_cost_7_7", 7, 7, 63);

        // DONE: load_start with a concurrent load_valid must not write.
        load_start = 1'b1; load_valid = 1'b1; load_data = 7'd99;
        tick();
        load_start = 1'b0; load_valid = 1'b0;
        chk("s4_jam_rst", 32'(jam_rst), 32'd1);
        chk("s4_done_clr", 32'(done), 32'd0);
        chk("s4_tl_clr", 32'(table_loaded), 32'd0);
        chk("s4_load_ready", 32'(load_ready), 32'd1);
        lookup("s4_cost_masked", 7, 7, 0);
        jam_valid = 1'b1;
        tick();
        jam_valid = 1'b0;
        chk("s4_jam_valid_ignored", 32'(done), 32'd0);
        chk("s4_still_loading", 32'(load_ready), 32'd1);
        load_entries("s2_ready_gappy", 1, 0, 64, 1'b1);
        chk("s2_table_loaded", 32'(table_loaded), 32'd1);
        lookup("s2_cost_0_0", 0, 0, 63);
        lookup("s2_cost_3_1", 3, 1, 38);
        lookup("s2_cost_2_5", 2, 5, 42);
        lookup("s2_cost_7_7", 7, 7, 0);

        // Reset from RUN, then reset mid-load after 30 handshakes.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("s5_rst_load_ready", 32'(load_ready), 32'd1);
        chk("s5_rst_jam_rst", 32'(jam_rst), 32'd1);
        chk("s5_rst_tl", 32'(table_loaded), 32'd0);
        lookup("s5_rst_cost", 0, 0, 0);
        load_entries("s5_ready_partial", 2, 0, 30, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("s5_midrst_tl", 32'(table_loaded), 32'd0);
        load_entries("s5_ready_a", 0, 0, 63, 1'b0);
        chk("s5_idx_restarted", 32'(table_loaded), 32'd0);
        load_entries("s5_ready_b", 0, 63, 1, 1'b0);
        chk("s5_table_loaded", 32'(table_loaded), 32'd1);
        chk("s5_jam_rst", 32'(jam_rst), 32'd0);
        lookup("s5_cost_2_5", 2, 5, 21);
        lookup("s5_cost_7_7", 7, 7, 63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
